// File: rtl/spi_frame_ctrl_if.sv
// Bus bundle between spi_frame_ctrl, the SPI serdes and the parameter memory.
//   spi_SSEL_sync : synchronized slave select, active low
//   dataReady     : one-cycle pulse, rxShiftReg holds a full word
//   rxShiftReg    : received word
//   txData/load   : next word for the serdes and its latch pulse
//   mem_*         : single-port memory, read data one cycle after mem_re
// master = controller side, slave = serdes/memory side.
interface spi_frame_ctrl_if #(
    parameter int unsigned PACKET_WIDTH = 8,
    parameter int unsigned ADDR_WIDTH   = 8
);
    logic                    spi_SSEL_sync;
    logic                    dataReady;
    logic [PACKET_WIDTH-1:0] rxShiftReg;
    logic [PACKET_WIDTH-1:0] txData;
    logic                    load;
    logic [ADDR_WIDTH-1:0]   mem_addr;
    logic [PACKET_WIDTH-1:0] mem_wdata;
    logic                    mem_we;
    logic                    mem_re;
    logic [PACKET_WIDTH-1:0] mem_rdata;

    modport master (
        input  spi_SSEL_sync,
        input  dataReady,
        input  rxShiftReg,
        input  mem_rdata,
        output txData,
        output load,
        output mem_addr,
        output mem_wdata,
        output mem_we,
        output mem_re
    );

    modport slave (
        output spi_SSEL_sync,
        output dataReady,
        output rxShiftReg,
        output mem_rdata,
        input  txData,
        input  load,
        input  mem_addr,
        input  mem_wdata,
        input  mem_we,
        input  mem_re
    );
endinterface

// File: rtl/spi_frame_ctrl.sv
// Frame-level SPI controller: decodes command/address words of a
// chip-select-delimited frame into auto-incrementing memory reads and writes,
// and queues read data (or status/zero words) into the serdes via load.
// Ports:
//   clk, rst  : clock, synchronous active-high reset
//   bus       : spi_frame_ctrl_if.master (serdes + memory signals)
//   err_count : saturating count of frames with an unknown command
module spi_frame_ctrl #(
    parameter int unsigned PACKET_WIDTH = 8,
    parameter int unsigned ADDR_WIDTH   = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    spi_frame_ctrl_if.master        bus,
    output logic [PACKET_WIDTH-1:0] err_count
);

    localparam logic [PACKET_WIDTH-1:0] CMD_READ  = PACKET_WIDTH'(1);
    localparam logic [PACKET_WIDTH-1:0] CMD_WRITE = PACKET_WIDTH'(2);
    localparam logic [PACKET_WIDTH-1:0] ERR_MAX   = {PACKET_WIDTH{1'b1}};

    typedef enum logic [2:0] {
        S_IDLE,
        S_CMD,
        S_ADDR,
        S_WRITE,
        S_READ,
        S_DISCARD
    } state_t;

    state_t                  state;
    logic                    ssel_q;
    logic                    is_read;
    logic [ADDR_WIDTH-1:0]   addr_q;
    logic                    rd_wait;
    logic [PACKET_WIDTH-1:0] tx_data_q;
    logic                    load_q;
    logic [ADDR_WIDTH-1:0]   mem_addr_q;
    logic [PACKET_WIDTH-1:0] mem_wdata_q;
    logic                    mem_we_q;
    logic                    mem_re_q;

    logic                    ssel_fall_c;
    logic [ADDR_WIDTH-1:0]   rx_addr_c;
    logic [ADDR_WIDTH-1:0]   addr_inc_c;

    assign ssel_fall_c = ssel_q && !bus.spi_SSEL_sync;
    assign rx_addr_c   = bus.rxShiftReg[ADDR_WIDTH-1:0];
    assign addr_inc_c  = addr_q + ADDR_WIDTH'(1);

    // Frame FSM with all outputs registered
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= S_IDLE;
            // track SSEL through reset so an already-low select is not an edge
            ssel_q      <= bus.spi_SSEL_sync;
            is_read     <= 1'b0;
            addr_q      <= '0;
            rd_wait     <= 1'b0;
            tx_data_q   <= '0;
            load_q      <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            mem_we_q    <= 1'b0;
            mem_re_q    <= 1'b0;
            err_count   <= '0;
        end else begin
            ssel_q   <= bus.spi_SSEL_sync;
            load_q   <= 1'b0;
            mem_we_q <= 1'b0;
            mem_re_q <= 1'b0;

            // read pipeline: mem_re -> mem_rdata valid -> load
            rd_wait <= mem_re_q;
            if (rd_wait) begin
                load_q    <= 1'b1;
                tx_data_q <= bus.mem_rdata;
            end

            case (state)
                S_IDLE: begin
                    if (ssel_fall_c) begin
                        // status byte goes out while the command word comes in
                        load_q    <= 1'b1;
                        tx_data_q <= err_count;
                        state     <= S_CMD;
                    end
                end

                S_CMD: begin
                    if (bus.dataReady) begin
                        load_q    <= 1'b1;
                        tx_data_q <= '0;
                        if (bus.rxShiftReg == CMD_READ) begin
                            is_read <= 1'b1;
                            state   <= S_ADDR;
                        end else if (bus.rxShiftReg == CMD_WRITE) begin
                            is_read <= 1'b0;
                            state   <= S_ADDR;
                        end else begin
                            if (err_count != ERR_MAX) begin
                                err_count <= err_count + PACKET_WIDTH'(1);
                            end
                            state <= S_DISCARD;
                        end
                    end
                end

                S_ADDR: begin
                    if (bus.dataReady) begin
                        addr_q <= rx_addr_c;
                        if (is_read) begin
                            mem_addr_q <= rx_addr_c;
                            mem_re_q   <= 1'b1;
                            state      <= S_READ;
                        end else begin
                            load_q    <= 1'b1;
                            tx_data_q <= '0;
                            state     <= S_WRITE;
                        end
                    end
                end

                S_WRITE: begin
                    if (bus.dataReady) begin
                        mem_we_q    <= 1'b1;
                        mem_addr_q  <= addr_q;
                        mem_wdata_q <= bus.rxShiftReg;
                        addr_q      <= addr_inc_c;
                        load_q      <= 1'b1;
                        tx_data_q   <= '0;
                    end
                end

                S_READ: begin
                    // each word clocked out prefetches the next address
                    if (bus.dataReady) begin
                        addr_q     <= addr_inc_c;
                        mem_addr_q <= addr_inc_c;
                        mem_re_q   <= 1'b1;
                    end
                end

                S_DISCARD: begin
                    if (bus.dataReady) begin
                        load_q    <= 1'b1;
                        tx_data_q <= '0;
                    end
                end

                default: begin
                    state <= S_IDLE;
                end
            endcase

            // SSEL release closes the frame; a word arriving in the same cycle
            // has already been committed above, but no new read or load goes out
            if (state != S_IDLE && bus.spi_SSEL_sync) begin
                state    <= S_IDLE;
                load_q   <= 1'b0;
                mem_re_q <= 1'b0;
                rd_wait  <= 1'b0;
            end
        end
    end

    assign bus.txData    = tx_data_q;
    assign bus.load      = load_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wdata = mem_wdata_q;
    assign bus.mem_we    = mem_we_q;
    assign bus.mem_re    = mem_re_q;

endmodule
